// File: rtl/data_ram_responder.sv
// Byte-addressable big-endian data RAM answering MemRead/MemWrite over a four-phase MFC handshake.
// Optional feature: define MISALIGN_TRAP_EN to trap misaligned halfword/word accesses via AlignErr.
module data_ram_responder #(
  parameter int ADDR_WIDTH = 8,
  parameter int LATENCY    = 2
) (
  input  logic                  Clk,
  input  logic                  RESET,
  input  logic                  MemRead,
  input  logic                  MemWrite,
  input  logic [1:0]            ramType,
  input  logic                  isSigned,
  input  logic [ADDR_WIDTH-1:0] Address,
  input  logic [31:0]           DataIn,
  output logic [31:0]           DataOut,
  output logic                  MFC,
  output logic                  Busy,
  output logic                  AlignErr,
  output logic [1:0]            dbg_state
);

  // Handshake: a request (MemRead/MemWrite) is held by the requester until MFC is
  // seen high; the responder keeps MFC high until both requests drop, then returns
  // to IDLE one edge later. A request is only accepted while in IDLE.

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WAIT = 2'd1,
    S_DONE = 2'd2
  } state_t;

  localparam int DEPTH = 1 << ADDR_WIDTH;

  state_t state, state_next;
  logic [3:0] cnt, cnt_next;
  logic       req;
  logic       do_access;

  logic [ADDR_WIDTH-1:0] lat_addr;
  logic [1:0]            lat_type;
  logic                  lat_signed;
  logic [31:0]           lat_data;
  logic                  lat_write;

  logic [7:0] mem [DEPTH];

  logic [ADDR_WIDTH-1:0] a0, a1, a2, a3;
  logic [7:0]            b0, b1, b2, b3;
  logic [31:0]           rd_data;
  logic                  wr_en;

  assign req       = MemRead | MemWrite;
  assign dbg_state = state;
  assign MFC       = (state == S_DONE);
  assign Busy      = (state != S_IDLE);

  always_comb begin
    state_next = state;
    cnt_next   = cnt;
    do_access  = 1'b0;
    case (state)
      S_IDLE: begin
        if (req) begin
          state_next = S_WAIT;
          cnt_next   = 4'(LATENCY - 1);
        end
      end
      S_WAIT: begin
        if (cnt == 4'd0) begin
          do_access  = 1'b1;
          state_next = S_DONE;
        end else begin
          cnt_next = cnt - 4'd1;
        end
      end
      S_DONE: begin
        if (!req) state_next = S_IDLE;
      end
      default: state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge Clk or negedge RESET) begin
    if (!RESET) begin
      state <= S_IDLE;
      cnt   <= 4'd0;
    end else begin
      state <= state_next;
      cnt   <= cnt_next;
    end
  end

  // Request fields are captured once at acceptance so later input changes are ignored.
  always_ff @(posedge Clk or negedge RESET) begin
    if (!RESET) begin
      lat_addr   <= '0;
      lat_type   <= 2'b00;
      lat_signed <= 1'b0;
      lat_data   <= 32'd0;
      lat_write  <= 1'b0;
    end else if (state == S_IDLE && req) begin
      lat_addr   <= Address;
      lat_type   <= ramType;
      lat_signed <= isSigned;
      lat_data   <= DataIn;
      lat_write  <= MemWrite;
    end
  end

  assign a0 = lat_addr;
  assign a1 = lat_addr + ADDR_WIDTH'(1);
  assign a2 = lat_addr + ADDR_WIDTH'(2);
  assign a3 = lat_addr + ADDR_WIDTH'(3);

  assign b0 = mem[a0];
  assign b1 = mem[a1];
  assign b2 = mem[a2];
  assign b3 = mem[a3];

  always_comb begin
    rd_data = 32'd0;
    case (lat_type)
      2'b00:   rd_data = {{24{lat_signed & b0[7]}}, b0};
      2'b01:   rd_data = {{16{lat_signed & b0[7]}}, b0, b1};
      default: rd_data = {b0, b1, b2, b3};
    endcase
  end

`ifdef MISALIGN_TRAP_EN
  logic misalign;

  assign misalign = ((lat_type == 2'b01) && lat_addr[0]) ||
                    (lat_type[1] && (lat_addr[1:0] != 2'b00));
  assign wr_en    = do_access & lat_write & ~misalign;

  always_ff @(posedge Clk or negedge RESET) begin
    if (!RESET) begin
      DataOut <= 32'd0;
    end else if (do_access && !lat_write) begin
      DataOut <= misalign ? 32'd0 : rd_data;
    end
  end

  always_ff @(posedge Clk or negedge RESET) begin
    if (!RESET) begin
      AlignErr <= 1'b0;
    end else if (do_access) begin
      AlignErr <= misalign;
    end else if (state == S_DONE && !req) begin
      AlignErr <= 1'b0;
    end
  end
`else
  assign wr_en    = do_access & lat_write;
  assign AlignErr = 1'b0;

  always_ff @(posedge Clk or negedge RESET) begin
    if (!RESET) begin
      DataOut <= 32'd0;
    end else if (do_access && !lat_write) begin
      DataOut <= rd_data;
    end
  end
`endif

  // Storage is never reset; only the access edge of a completed WAIT may write it.
  always_ff @(posedge Clk) begin
    if (wr_en) begin
      case (lat_type)
        2'b00: mem[a0] <= lat_data[7:0];
        2'b01: begin
          mem[a0] <= lat_data[15:8];
          mem[a1] <= lat_data[7:0];
        end
        default: begin
          mem[a0] <= lat_data[31:24];
          mem[a1] <= lat_data[23:16];
          mem[a2] <= lat_data[15:8];
          mem[a3] <= lat_data[7:0];
        end
      endcase
    end
  end

endmodule

// File: tb/tb_data_ram_responder.sv
// Self-checking bench for data_ram_responder: byte-level memory model plus an expected-DataOut queue.
// Follows MISALIGN_TRAP_EN the same way the design does.
module tb_data_ram_responder;

  localparam int LAT = 2;
`ifdef MISALIGN_TRAP_EN
  localparam bit TRAP = 1'b1;
`else
  localparam bit TRAP = 1'b0;
`endif

  logic        clk;
  logic        rst_n;
  logic        mem_read;
  logic        mem_write;
  logic [1:0]  ram_type;
  logic        is_signed;
  logic [7:0]  address;
  logic [31:0] data_in;
  logic [31:0] data_out;
  logic        mfc;
  logic        busy;
  logic        align_err;
  logic [1:0]  dbg_state;

  int checks = 0;
  int errors = 0;

  logic [7:0]  model_mem [256];
  logic [31:0] exp_q [$];
  logic        align_q [$];
  logic [31:0] exp_dout;

  data_ram_responder #(.ADDR_WIDTH(8), .LATENCY(LAT)) dut (
    .Clk(clk), .RESET(rst_n), .MemRead(mem_read), .MemWrite(mem_write),
    .ramType(ram_type), .isSigned(is_signed), .Address(address), .DataIn(data_in),
    .DataOut(data_out), .MFC(mfc), .Busy(busy), .AlignErr(align_err),
    .dbg_state(dbg_state)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=0x%08h exp=0x%08h", tag, got, exp);
    end
  endtask

  function automatic int nbytes(input logic [1:0] typ);
    return (typ == 2'b00) ? 1 : (typ == 2'b01) ? 2 : 4;
  endfunction

  function automatic bit model_mis(input logic [1:0] typ, input logic [7:0] addr);
    int n = nbytes(typ);
    return TRAP && (n > 1) && ((int'(addr) % n) != 0);
  endfunction

  task automatic model_write(input logic [1:0] typ, input logic [7:0] addr, input logic [31:0] din);
    int n = nbytes(typ);
    if (!model_mis(typ, addr))
      for (int i = 0; i < n; i++)
        model_mem[8'(int'(addr) + i)] = 8'(din >> (8 * (n - 1 - i)));
  endtask

  function automatic logic [31:0] model_read(input logic [1:0] typ, input logic sgn, input logic [7:0] addr);
    int n = nbytes(typ);
    logic [31:0] v = 32'd0;
    if (model_mis(typ, addr)) return 32'd0;
    for (int i = 0; i < n; i++)
      v = {v[23:0], model_mem[8'(int'(addr) + i)]};
    if (sgn && n < 4 && v[8*n-1])
      for (int b = 8 * n; b < 32; b++) v[b] = 1'b1;
    return v;
  endfunction

  // driver: one full handshake, with optional extra request-hold cycles in DONE
  task automatic transact(input logic rd, input logic wr, input logic [1:0] typ,
                          input logic sgn, input logic [7:0] addr, input logic [31:0] din,
                          input int hold);
    int n;
    logic [31:0] e;
    logic ea;
    if (wr) model_write(typ, addr, din);
    else exp_dout = model_read(typ, sgn, addr);
    exp_q.push_back(exp_dout);
    align_q.push_back(model_mis(typ, addr));

    @(negedge clk);
    mem_read = rd; mem_write = wr; ram_type = typ; is_signed = sgn;
    address = addr; data_in = din;
    @(posedge clk); #1;
    check_val("busy_after_accept", {31'd0, busy}, 32'd1);
    // scramble inputs: the in-flight access must ignore them
    ram_type = 2'(~typ); is_signed = ~sgn; address = ~addr; data_in = ~din;
    n = 0;
    while (!mfc && n < 40) begin
      @(posedge clk); #1;
      n++;
    end
    if (n >= 40) begin
      errors++;
      $display("FAIL mfc_timeout got=%0d exp=%0d", n, LAT);
    end
    check_val("mfc_latency", n, LAT);
    e  = exp_q.pop_front();
    ea = align_q.pop_front();
    check_val(wr ? "dout_hold_on_write" : "read_data", data_out, e);
    check_val("align_err_done", {31'd0, align_err}, {31'd0, ea});
    for (int h = 0; h < hold; h++) begin
      @(posedge clk); #1;
      check_val("mfc_hold", {31'd0, mfc}, 32'd1);
    end
    mem_read = 1'b0; mem_write = 1'b0;
    @(posedge clk); #1;
    check_val("mfc_drop", {31'd0, mfc}, 32'd0);
    check_val("busy_drop", {31'd0, busy}, 32'd0);
    check_val("align_err_idle", {31'd0, align_err}, 32'd0);
  endtask

  task automatic check_reset_outputs(input string tag);
    check_val({tag, "_dout"}, data_out, 32'd0);
    check_val({tag, "_mfc"}, {31'd0, mfc}, 32'd0);
    check_val({tag, "_busy"}, {31'd0, busy}, 32'd0);
    check_val({tag, "_align"}, {31'd0, align_err}, 32'd0);
    check_val({tag, "_state"}, {30'd0, dbg_state}, 32'd0);
  endtask

  initial begin
    logic [7:0]  base;
    logic [1:0]  typ;
    logic [7:0]  raddr;
    logic [31:0] wdata;

    rst_n = 1'b0; mem_read = 1'b0; mem_write = 1'b0; ram_type = 2'b00;
    is_signed = 1'b0; address = 8'd0; data_in = 32'd0;
    exp_dout = 32'd0;
    repeat (3) @(posedge clk);
    #2;
    check_reset_outputs("reset");
    @(negedge clk); rst_n = 1'b1;

    // word write then reads of the whole word and its end bytes
    transact(1'b0, 1'b1, 2'b10, 1'b0, 8'h10, 32'hDEADBEEF, 0);
    transact(1'b1, 1'b0, 2'b10, 1'b0, 8'h10, 32'h0, 0);
    transact(1'b1, 1'b0, 2'b00, 1'b0, 8'h10, 32'h0, 0);
    transact(1'b1, 1'b0, 2'b00, 1'b0, 8'h13, 32'h0, 0);
    // halfword read with the request held in DONE
    transact(1'b1, 1'b0, 2'b01, 1'b1, 8'h12, 32'h0, 5);

    // signed / unsigned byte extension
    transact(1'b0, 1'b1, 2'b00, 1'b0, 8'h20, 32'h00000080, 0);
    transact(1'b1, 1'b0, 2'b00, 1'b1, 8'h20, 32'h0, 0);
    transact(1'b1, 1'b0, 2'b00, 1'b0, 8'h20, 32'h0, 0);

    // reset in the middle of WAIT aborts the write
    transact(1'b0, 1'b1, 2'b10, 1'b0, 8'h40, 32'h0BADF00D, 0);
    @(negedge clk);
    mem_write = 1'b1; ram_type = 2'b10; address = 8'h40; data_in = 32'h12345678;
    @(posedge clk); #1;
    #2 rst_n = 1'b0;
    #1 check_reset_outputs("abort");
    mem_write = 1'b0;
    exp_dout = 32'd0;
    @(negedge clk); rst_n = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(posedge clk); #1;
      check_val("mfc_after_abort", {31'd0, mfc}, 32'd0);
    end
    transact(1'b1, 1'b0, 2'b10, 1'b0, 8'h40, 32'h0, 0);

    // address wrap and alignment
    transact(1'b0, 1'b1, 2'b00, 1'b0, 8'hFE, 32'h11, 0);
    transact(1'b0, 1'b1, 2'b00, 1'b0, 8'hFF, 32'h22, 0);
    transact(1'b0, 1'b1, 2'b00, 1'b0, 8'h00, 32'h33, 0);
    transact(1'b0, 1'b1, 2'b00, 1'b0, 8'h01, 32'h44, 0);
    transact(1'b0, 1'b1, 2'b10, 1'b0, 8'hFE, 32'hA1B2C3D4, 0);
    transact(1'b1, 1'b0, 2'b00, 1'b0, 8'hFE, 32'h0, 0);
    transact(1'b1, 1'b0, 2'b00, 1'b0, 8'hFF, 32'h0, 0);
    transact(1'b1, 1'b0, 2'b00, 1'b0, 8'h00, 32'h0, 0);
    transact(1'b1, 1'b0, 2'b00, 1'b0, 8'h01, 32'h0, 0);
    transact(1'b1, 1'b0, 2'b01, 1'b0, 8'h11, 32'h0, 0);
    transact(1'b1, 1'b0, 2'b10, 1'b0, 8'hFE, 32'h0, 0);

    // simultaneous read and write: write wins, DataOut untouched
    transact(1'b1, 1'b1, 2'b00, 1'b0, 8'h30, 32'h00000055, 0);
    transact(1'b1, 1'b0, 2'b00, 1'b0, 8'h30, 32'h0, 0);

    // randomized aligned write / read pairs
    for (int i = 0; i < 8; i++) begin
      base  = 8'h80 + 8'(4 * $urandom_range(0, 15));
      wdata = $urandom();
      transact(1'b0, 1'b1, 2'b10, 1'b0, base, wdata, $urandom_range(0, 2));
      typ   = 2'($urandom_range(0, 3));
      raddr = base;
      if (typ == 2'b00) raddr = base + 8'($urandom_range(0, 3));
      else if (typ == 2'b01) raddr = base + 8'(2 * $urandom_range(0, 1));
      transact(1'b1, 1'b0, typ, 1'($urandom_range(0, 1)), raddr, 32'h0, 0);
    end

    check_val("queue_empty", exp_q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
